irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt controller feeding the single-cycle CPU's decode stage.
- Latches edge-triggered requests from peripherals, applies a software mask and a global enable, and picks the lowest-numbered active source.
- Drives the IRQ input of the instruction-decode control unit and holds it until the datapath acknowledges taking the interrupt vector.
- Blocks further requests until the handler returns; memory-mapped config port on the peripheral bus.

Parameters:
- NSRC, 4, number of interrupt sources (1..8)
- CW, 3, width of the cause field; must satisfy 2^CW > NSRC

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- src_irq  in  NSRC  raw peripheral request lines, sampled each clk
- kernel_mode  in  1  PC[31] of the current instruction; 1 = handler/kernel code
- irq_ack  in  1  one-cycle pulse: datapath took PCSrc=100 this cycle
- eret  in  1  one-cycle pulse: handler return (jr $26 from kernel) executed
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  register select: 0 mask, 1 pending, 2 cause, 3 status
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational on cfg_addr
- IRQ  out  1  interrupt request to the control unit
- irq_busy  out  1  high while in REQ or SERVICE

Behaviour:
- Reset, applied synchronously at any time including mid-service:
  - state=IDLE, IRQ=0, irq_busy=0.
  - mask=0, pending=0, cause=0, status.en=0, src_prev=0.
- Edge detect:
  - src_prev<=src_irq every cycle.
  - Rising edge of src_irq[i] relative to src_prev[i] sets pending[i] at that clk edge.
- Registers:
  - mask: NSRC bits, read/write.
  - pending: read; write-1-to-clear.
  - cause: CW bits, read-only, zero-extended on read.
  - status: bit0=en is read/write; bits 2:1 are read-only and return the state encoding.
  - Unused read bits return 0. Writes to read-only fields are ignored.
- Collisions:
  - A pending set and a W1C clear of the same bit in the same cycle: set wins.
- Arbitration:
  - active = pending & mask. Winner = lowest index i with active[i]=1.
- FSM encoding: IDLE=0, REQ=1, SERVICE=2. IRQ = (state==REQ), decoded from the state register only, so it never glitches.
- IDLE:
  - If en=1, active!=0 and kernel_mode=0: cause<=winner and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - irq_ack=1: pending[cause] cleared, go to SERVICE. Ack takes priority over every other event this cycle.
  - Else if active[cause]=0 (cleared by W1C or masked) or en=0: go to IDLE (withdrawn request). cause keeps its value.
  - Else stay in REQ. No re-arbitration in REQ, so cause is stable while IRQ=1.
- SERVICE:
  - IRQ=0. New edges still set pending.
  - eret=1: go to IDLE.
  - irq_ack in SERVICE is ignored.
- Latency:
  - Source rising at sample edge k: pending set after edge k; REQ and IRQ=1 after edge k+1, i.e. 2 cycles.
  - After eret at edge m: IDLE after m; if still active and kernel_mode=0, IRQ=1 after m+1.
- Stray pulses: irq_ack or eret in IDLE has no effect.
- Level-held source: a source held high does not re-pend after its pending bit is cleared; it needs a new rising edge.

Test Plan:
- Basic request: reset, write mask=0xF, status=1; pulse src_irq[2] at cycle 10 -> pending=0x4 at cycle 11, IRQ=1 from cycle 12, cause=2. irq_ack at cycle 15 -> IRQ=0 at cycle 16, pending=0, irq_busy=1. eret at cycle 20 -> state IDLE, irq_busy=0.
- Priority: raise src 3 and src 1 on the same edge -> cause=1. After ack and eret -> IRQ again with cause=3 two cycles after eret.
- Kernel block and mask: kernel_mode=1 with pending 0x1 -> IRQ stays 0; drop kernel_mode -> IRQ=1 two cycles later. With mask=0x0, src pulse -> pending=1, IRQ=0; readback addr1 = 0x1.
- Withdraw: in REQ with cause=0, W1C pending=0x1 -> IRQ=0 next cycle, state IDLE, no SERVICE entered. Repeat with W1C in the same cycle as irq_ack -> SERVICE entered, pending[0]=0.
- Collision and reset: src_irq[0] edge in the same cycle as W1C of bit 0 -> pending[0]=1. Assert reset while in SERVICE -> next cycle IRQ=0, irq_busy=0, mask=0, status=0, all cfg reads return 0.

Source files
------------

// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-triggered interrupt controller for the CPU decode stage.
// Latches rising edges of peripheral requests into a pending register, masks
// them with a software mask and a global enable, and raises IRQ for the
// lowest-numbered active source. IRQ is held until the datapath acknowledges
// the vector. Further requests are then blocked until the handler returns.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   src_irq         raw peripheral request lines (rising-edge sensitive)
//   kernel_mode     1 while executing kernel/handler code (blocks new IRQs)
//   irq_ack         datapath took the interrupt vector this cycle
//   eret            handler return executed this cycle
//   cfg_we/addr/wdata  config write port (0 mask, 1 pending W1C, 2 cause, 3 status)
//   cfg_rdata       combinational read data selected by cfg_addr
//   IRQ             interrupt request to the control unit (state == REQ)
//   irq_busy        high while in REQ or SERVICE
module irq_sequencer #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned CW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            kernel_mode,
    input  logic            irq_ack,
    input  logic            eret,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic            IRQ,
    output logic            irq_busy
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [CW-1:0]     cause_q, cause_d;
    logic              en_q, en_d;
    logic [NSRC-1:0]   src_prev_q, src_prev_d;

    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   w1c;
    logic [NSRC-1:0]   pending_nw;
    logic [NSRC-1:0]   active_q;
    logic [NSRC-1:0]   active_nw;
    logic [NSRC-1:0]   cause_oh;
    logic [NSRC-1:0]   ack_clr;
    logic [CW-1:0]     winner;

    // Upper write-data bits have no destination.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[DW-1:NSRC];

    // State register and config/pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            pending_q  <= '0;
            cause_q    <= '0;
            en_q       <= 1'b0;
            src_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            cause_q    <= cause_d;
            en_q       <= en_d;
            src_prev_q <= src_prev_d;
        end
    end

    // Config writes, edge detect and pending update (new edges beat any clear).
    always_comb begin
        mask_d     = mask_q;
        en_d       = en_q;
        w1c        = '0;
        src_prev_d = src_irq;
        rise       = src_irq & ~src_prev_q;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    mask_d = cfg_wdata[NSRC-1:0];
                2'd1:    w1c    = cfg_wdata[NSRC-1:0];
                2'd3:    en_d   = cfg_wdata[0];
                default: ;
            endcase
        end
        // Pending/mask as they will stand after this edge, ignoring the ack clear.
        pending_nw = (pending_q & ~w1c) | rise;
        active_nw  = pending_nw & mask_d;
        pending_d  = (pending_q & ~(w1c | ack_clr)) | rise;
    end

    // Arbitration: lowest-numbered active source wins.
    always_comb begin
        active_q = pending_q & mask_q;
        winner   = '0;
        cause_oh = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (active_q[i]) winner = CW'(i);
        end
        for (int i = 0; i < int'(NSRC); i++) begin
            cause_oh[i] = (cause_q == CW'(i));
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_clr = '0;
        case (state_q)
            IDLE: begin
                if (en_q && (|active_q) && !kernel_mode) begin
                    cause_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_clr = cause_oh;
                    state_d = SERVICE;
                end else if (!(|(active_nw & cause_oh)) || !en_d) begin
                    // Request withdrawn by W1C, mask or disable; cause is kept.
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    assign IRQ      = (state_q == REQ);
    assign irq_busy = (state_q == REQ) || (state_q == SERVICE);

    // Read mux; unused bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata = DW'(mask_q);
            2'd1: cfg_rdata = DW'(pending_q);
            2'd2: cfg_rdata = DW'(cause_q);
            2'd3: cfg_rdata = {29'd0, state_q, en_q};
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with an expected-value queue.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        kernel_mode;
    logic        irq_ack;
    logic        eret;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        IRQ;
    logic        irq_busy;

    int n_cmp = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    irq_sequencer #(.NSRC(4), .CW(3)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq), .kernel_mode(kernel_mode),
        .irq_ack(irq_ack), .eret(eret), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .IRQ(IRQ), .irq_busy(irq_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] v);
        logic [31:0] d;
        expect_val(tag, v);
        cfg_read(a, d);
        check(d);
    endtask

    task automatic out_check(input string tag, input logic irq_e, input logic busy_e);
        expect_val({tag, "_irq"}, 32'(irq_e));
        check(32'(IRQ));
        expect_val({tag, "_busy"}, 32'(busy_e));
        check(32'(irq_busy));
    endtask

    // Rising edge on the given sources, then released.
    task automatic pulse_src(input logic [3:0] v);
        src_irq = v;
        step();
        src_irq = '0;
        step();
    endtask

    task automatic do_ack();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; src_irq = '0; kernel_mode = 1'b0; irq_ack = 1'b0;
        eret = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        out_check("rst", 1'b0, 1'b0);
        rd_check("rst_mask", 2'd0, 32'h0);
        rd_check("rst_pend", 2'd1, 32'h0);
        rd_check("rst_status", 2'd3, 32'h0);

        // Basic request on source 2
        cfg_write(2'd0, 32'hF);
        cfg_write(2'd3, 32'h1);
        src_irq = 4'h4;
        step();
        src_irq = '0;
        rd_check("basic_pend_k", 2'd1, 32'h4);
        out_check("basic_k", 1'b0, 1'b0);
        step();
        out_check("basic_req", 1'b1, 1'b1);
        rd_check("basic_cause", 2'd2, 32'd2);
        rd_check("basic_status_req", 2'd3, 32'h3);
        step(); step();
        out_check("basic_hold", 1'b1, 1'b1);
        do_ack();
        out_check("basic_svc", 1'b0, 1'b1);
        rd_check("basic_pend_clr", 2'd1, 32'h0);
        rd_check("basic_status_svc", 2'd3, 32'h5);
        do_ack();
        rd_check("svc_ack_ignored", 2'd3, 32'h5);
        step(); step();
        do_eret();
        out_check("basic_eret", 1'b0, 1'b0);
        rd_check("basic_status_idle", 2'd3, 32'h1);

        // Stray ack/eret in IDLE
        irq_ack = 1'b1; eret = 1'b1; step(); irq_ack = 1'b0; eret = 1'b0;
        rd_check("stray_status", 2'd3, 32'h1);

        // Priority: sources 3 and 1 together
        pulse_src(4'hA);
        out_check("prio_req", 1'b1, 1'b1);
        rd_check("prio_cause1", 2'd2, 32'd1);
        do_ack();
        rd_check("prio_pend_left", 2'd1, 32'h8);
        step();
        do_eret();
        out_check("prio_after_eret", 1'b0, 1'b0);
        step();
        out_check("prio_req2", 1'b1, 1'b1);
        rd_check("prio_cause3", 2'd2, 32'd3);
        do_ack();
        do_eret();

        // Kernel-mode block
        kernel_mode = 1'b1;
        pulse_src(4'h1);
        step(); step();
        out_check("kern_block", 1'b0, 1'b0);
        rd_check("kern_pend", 2'd1, 32'h1);
        kernel_mode = 1'b0;
        step(); step();
        out_check("kern_release", 1'b1, 1'b1);
        rd_check("kern_cause", 2'd2, 32'd0);
        do_ack();
        do_eret();

        // Mask zero
        cfg_write(2'd0, 32'h0);
        pulse_src(4'h1);
        step();
        out_check("mask0", 1'b0, 1'b0);
        rd_check("mask0_pend", 2'd1, 32'h1);
        cfg_write(2'd1, 32'h1);
        rd_check("mask0_w1c", 2'd1, 32'h0);
        cfg_write(2'd0, 32'hF);

        // Level-held source does not re-pend after ack
        src_irq = 4'h2;
        step(); step();
        out_check("level_req", 1'b1, 1'b1);
        do_ack();
        step(); step();
        rd_check("level_no_repend", 2'd1, 32'h0);
        do_eret();
        step();
        out_check("level_idle", 1'b0, 1'b0);
        src_irq = '0;
        step();

        // Withdraw by W1C while in REQ
        pulse_src(4'h1);
        out_check("wd_req", 1'b1, 1'b1);
        cfg_write(2'd1, 32'h1);
        out_check("wd_drop", 1'b0, 1'b0);
        rd_check("wd_status", 2'd3, 32'h1);
        step(); step();
        out_check("wd_stays_idle", 1'b0, 1'b0);
        rd_check("wd_cause_kept", 2'd2, 32'd0);

        // W1C together with ack: ack wins
        pulse_src(4'h1);
        out_check("wdack_req", 1'b1, 1'b1);
        irq_ack = 1'b1;
        cfg_write(2'd1, 32'h1);
        irq_ack = 1'b0;
        rd_check("wdack_status", 2'd3, 32'h5);
        rd_check("wdack_pend", 2'd1, 32'h0);
        do_eret();

        // Edge and W1C of the same bit collide: set wins
        cfg_write(2'd0, 32'h0);
        src_irq = 4'h1;
        cfg_write(2'd1, 32'h1);
        src_irq = '0;
        rd_check("coll_pend", 2'd1, 32'h1);
        cfg_write(2'd1, 32'h1);
        cfg_write(2'd0, 32'hF);

        // Reset in SERVICE
        pulse_src(4'h4);
        do_ack();
        rd_check("rst_svc_status", 2'd3, 32'h5);
        src_irq = 4'h8;
        step();
        src_irq = '0;
        do_reset();
        out_check("rst_svc", 1'b0, 1'b0);
        rd_check("rst_svc_mask", 2'd0, 32'h0);
        rd_check("rst_svc_pend", 2'd1, 32'h0);
        rd_check("rst_svc_cause", 2'd2, 32'h0);
        rd_check("rst_svc_status", 2'd3, 32'h0);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
